// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART TX FIFO write port between two byte streams.
// Define UART_ARB_STATS_EN to build the per-requester accepted-byte counters.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_valid0,
    input  logic [7:0]       i_data0,
    input  logic             i_last0,
    output logic             o_ready0,
    input  logic             i_valid1,
    input  logic [7:0]       i_data1,
    input  logic             i_last1,
    output logic             o_ready1,
    input  logic             i_fifoFull,
    output logic             o_fifoWrEn,
    output logic [7:0]       o_fifoData,
    output logic [1:0]       o_grant,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_count0,
    output logic [CNT_W-1:0] o_count1
);

    localparam int TMR_W = 16;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t           state;
    logic             favour1;
    logic [TMR_W-1:0] idle_cnt;

    logic       xfer0;
    logic       xfer1;
    logic       xfer;
    logic       xfer_last;
    logic [7:0] xfer_data;
    logic       expire;

    // Blocking ready while a write is outstanding caps the rate at one byte
    // per two cycles, so a full flag that lags by a cycle can never overrun.
    assign o_ready0  = (state == GRANT0) & ~i_fifoFull & ~o_fifoWrEn;
    assign o_ready1  = (state == GRANT1) & ~i_fifoFull & ~o_fifoWrEn;
    assign xfer0     = i_valid0 & o_ready0;
    assign xfer1     = i_valid1 & o_ready1;
    assign xfer      = xfer0 | xfer1;
    assign xfer_last = (xfer0 & i_last0) | (xfer1 & i_last1);
    assign xfer_data = xfer1 ? i_data1 : i_data0;
    assign expire    = (state != IDLE) & ~xfer & ~i_fifoFull & (idle_cnt == TMR_LAST);
    assign o_grant   = state;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state      <= IDLE;
            favour1    <= 1'b0;
            idle_cnt   <= '0;
            o_fifoWrEn <= 1'b0;
            o_fifoData <= 8'h00;
            o_timeout  <= 1'b0;
        end else begin
            o_fifoWrEn <= xfer;
            o_timeout  <= 1'b0;
            if (xfer) begin
                o_fifoData <= xfer_data;
            end
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (i_valid0 && (!i_valid1 || !favour1)) begin
                        state <= GRANT0;
                    end else if (i_valid1) begin
                        state <= GRANT1;
                    end
                end
                default: begin
                    // A last-byte transfer outranks a same-cycle expiry.
                    if (xfer_last) begin
                        state    <= IDLE;
                        favour1  <= (state == GRANT0);
                        idle_cnt <= '0;
                    end else if (expire) begin
                        state     <= IDLE;
                        favour1   <= (state == GRANT0);
                        o_timeout <= 1'b1;
                        idle_cnt  <= '0;
                    end else if (xfer) begin
                        idle_cnt <= '0;
                    end else if (!i_fifoFull) begin
                        idle_cnt <= idle_cnt + TMR_W'(1);
                    end
                end
            endcase
        end
    end

`ifdef UART_ARB_STATS_EN
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            o_count0 <= '0;
            o_count1 <= '0;
        end else begin
            if (xfer0) begin
                o_count0 <= o_count0 + CNT_W'(1);
            end
            if (xfer1) begin
                o_count1 <= o_count1 + CNT_W'(1);
            end
        end
    end
`else
    assign o_count0 = '0;
    assign o_count1 = '0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO write port between two byte-stream requesters, e.g. the CPU IO path (requester 0) and a debug/monitor source (requester 1).
- Uses round-robin arbitration with packet locking: a grant is held until the requester's last byte or until an idle timeout.
- Sits in the design-clock domain, in front of the TX FIFO's write side.

Parameters:
- TIMEOUT_CYCLES, 256: cycles without an accepted byte, while granted, before the grant is revoked. Legal range is 2..65535.
- CNT_W, 16: width of the per-requester byte counters (optional feature only).

Ports:
- i_clk  in  1  design clock; all logic on the rising edge.
- i_resetn  in  1  asynchronous, active-low reset.
- i_valid0  in  1  requester 0 has a byte.
- i_data0  in  8  requester 0 byte.
- i_last0  in  1  requester 0 byte is the last byte of its packet.
- o_ready0  out  1  requester 0 byte accepted this cycle when i_valid0 is also high.
- i_valid1, i_data1, i_last1, o_ready1: same as above, for requester 1.
- i_fifoFull  in  1  TX FIFO full flag.
- o_fifoWrEn  out  1  registered FIFO write strobe.
- o_fifoData  out  8  registered FIFO write data.
- o_grant  out  2  one-hot current owner; 00 when idle.
- o_timeout  out  1  one-cycle pulse when a grant is revoked by timeout.
- o_count0, o_count1  out  CNT_W  accepted-byte counters (optional feature).

Behaviour:
- Reset values (async assert, sync release):
  - state IDLE; o_grant 00; o_fifoWrEn 0; o_fifoData 00; o_timeout 0.
  - priority pointer: requester 0 favoured.
  - timeout counter 0; o_count0/1 0.
- States:
  - IDLE: o_ready0/1 = 0.
    - Only i_valid0 high -> GRANT0. Only i_valid1 high -> GRANT1.
    - Both high -> the requester favoured by the pointer.
    - Neither high -> stay in IDLE.
    - Grant takes effect the cycle after the valid is seen (one-cycle arbitration latency).
  - GRANTk: o_readyk = ~i_fifoFull & ~o_fifoWrEn; the other ready is 0. o_ready is combinational from these registered signals only.
- Transfer: i_validk & o_readyk at a rising edge.
  - Next cycle: o_fifoWrEn = 1 and o_fifoData = i_datak.
  - Otherwise o_fifoWrEn = 0; o_fifoData holds its last value.
  - Consequences: at most one write every 2 cycles, and the FIFO is never overrun even with a one-cycle-late full flag.
- End of packet: transfer with i_lastk = 1 -> IDLE. The pointer then favours the other requester, giving fair alternation per packet.
- Timeout:
  - The counter clears on entering GRANTk and on every transfer, and increments each GRANTk cycle without a transfer.
  - Cycles stalled by i_fifoFull do NOT count; the counter holds while i_fifoFull = 1.
  - Counter reaches TIMEOUT_CYCLES-1 and no transfer that cycle -> IDLE, o_timeout = 1 for one cycle, pointer favours the other requester.
- Simultaneous transfer-with-last and timeout in the same cycle: the transfer wins; no o_timeout pulse.
- A requester dropping i_valid mid-packet is legal. The grant persists until last or timeout.
- Reset mid-packet: everything returns to reset values immediately. A pending o_fifoWrEn is cancelled, i.e. the byte is dropped.
- o_grant is registered and equals the state encoding: GRANT0 = 01, GRANT1 = 10.

Optional Feature:
- Macro: UART_ARB_STATS_EN.
- Defined:
  - o_count0/o_count1 each increment by 1 on every transfer from their requester.
  - Modulo 2^CNT_W; wrap from all-ones to 0.
  - Cleared only by reset.
- Undefined: counters are not implemented; o_count0/o_count1 are tied to 0. The port list is unchanged.

Test Plan:
1. Requester 0 sends bytes 41,42,43 with last on 43; requester 1 idle -> o_grant 01 one cycle after valid; o_fifoWrEn pulses on alternate cycles with data 41,42,43; then IDLE, o_grant 00.
2. Both requesters valid with 2-byte packets (0: A0,A1; 1: B0,B1) held continuously -> FIFO sees A0,A1,B0,B1,A0,A1... in strict per-packet alternation.
3. Grant requester 1, send 1 byte without last, then drop valid, TIMEOUT_CYCLES=8 -> o_timeout pulses exactly 8 cycles after the last transfer; o_grant 00; a pending requester 0 is granted next.
4. Hold i_fifoFull=1 for 20 cycles while granted with valid high, TIMEOUT_CYCLES=8 -> no writes, no timeout; release full -> byte written 1 cycle after the transfer edge.
5. Assert reset while o_fifoWrEn=1 mid-packet -> o_fifoWrEn, o_grant, o_timeout go 0 asynchronously; after release, requester 0 wins a simultaneous request.
6. With UART_ARB_STATS_EN and CNT_W=4: send 17 bytes from requester 0 -> o_count0 = 1, o_count1 = 0. Without the macro -> both counters are 0.
